// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg : shared constants and state encoding for the timer_dev block
// Optional feature macro: TIMER_PRESCALE_EN (see timer_dev)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

   // Register word offsets (bus address bits [3:2])
   localparam logic [1:0] CTRL_OFS   = 2'd0;
   localparam logic [1:0] PRESET_OFS = 2'd1;
   localparam logic [1:0] COUNT_OFS  = 2'd2;

   // CTRL.MODE encodings; any other value behaves as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // CTRL bit positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_PS_LSB   = 4;
   localparam int CTRL_PS_MSB   = 6;
   localparam int CTRL_W        = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler : free-running tick generator, one tick every 2^PS cycles.
// Only instantiated when TIMER_PRESCALE_EN is defined.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_prescaler
   import timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr_i,
   input  logic [2:0] ps_i,
   output logic       tick_o
);

   logic [6:0] cnt_q;
   logic [6:0] w_mask;

   // Terminal count is 2^PS - 1; PS = 7 wraps the shift to 0, giving 7'h7F
   assign w_mask = (7'd1 << ps_i) - 7'd1;
   assign tick_o = (cnt_q == w_mask);

   // Count up, restarting after each tick or on an explicit clear
   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         cnt_q <= '0;
      end else if (tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 7'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/timer_dev.sv
// ---------------------------------------------------------------------------
// timer_dev : bus-attached countdown timer with one-shot and auto-reload
//             modes and a masked interrupt request.
// Optional  : define TIMER_PRESCALE_EN to enable CTRL.PS and the prescaler.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_dev
   import timer_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             irq
);

`ifdef TIMER_PRESCALE_EN
   localparam logic [CTRL_W-1:0] CTRL_WMASK = 7'h7F;
`else
   localparam logic [CTRL_W-1:0] CTRL_WMASK = 7'h0F;
`endif
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [CTRL_W-1:0]   ctrl_q;
   logic [WIDTH-1:0]    preset_q;
   logic [WIDTH-1:0]    count_q;
   logic                irq_flag_q;

   logic                w_ctrl_wr;
   logic                w_en;
   logic                w_tick;

   assign w_ctrl_wr = we && (addr == CTRL_OFS);
   // A same-cycle CTRL write overrides EN so disabling takes effect at once
   assign w_en      = w_ctrl_wr ? wdata[CTRL_EN_BIT] : ctrl_q[CTRL_EN_BIT];
   assign irq       = ctrl_q[CTRL_IM_BIT] & irq_flag_q;

`ifdef TIMER_PRESCALE_EN
   logic w_ps_clr;
   assign w_ps_clr = (state_q == LOAD) || w_ctrl_wr;

   timer_prescaler u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (w_ps_clr),
      .ps_i   (ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB]),
      .tick_o (w_tick)
   );
`else
   assign w_tick = 1'b1;
`endif

   // Combinational register read mux, no wait states
   always_comb begin
      rdata = '0;
      case (addr)
         CTRL_OFS:   rdata = {{(WIDTH-CTRL_W){1'b0}}, ctrl_q};
         PRESET_OFS: rdata = preset_q;
         COUNT_OFS:  rdata = count_q;
         default:    rdata = '0;
      endcase
   end

   // Countdown FSM with bus register writes; a CTRL write is applied last
   // so it overrides any FSM update of EN or irq_flag in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         if (we && (addr == PRESET_OFS)) begin
            preset_q <= wdata;
         end

         case (state_q)
            IDLE: begin
               if (ctrl_q[CTRL_EN_BIT]) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               count_q    <= preset_q;
               // Ends the one-cycle reload pulse raised on leaving INT
               irq_flag_q <= 1'b0;
               state_q    <= CNT;
            end
            CNT: begin
               if (!w_en) begin
                  state_q <= IDLE;
               end else if (w_tick) begin
                  if (count_q == '0) begin
                     state_q <= INT;
                  end else begin
                     count_q <= count_q - ONE;
                  end
               end
            end
            INT: begin
               // The flag is registered out of INT, so it is seen one edge
               // after the zero count is detected
               irq_flag_q <= 1'b1;
               if (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD) begin
                  state_q <= LOAD;
               end else begin
                  ctrl_q[CTRL_EN_BIT] <= 1'b0;
                  state_q             <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (w_ctrl_wr) begin
            ctrl_q     <= wdata[CTRL_W-1:0] & CTRL_WMASK;
            irq_flag_q <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_timer_dev.sv
// ---------------------------------------------------------------------------
// tb_timer_dev : directed self-checking bench for timer_dev
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_timer_dev;
   import timer_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   timer_dev #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus write: drive after the falling edge, commit on the next rising edge
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we    = 1'b0;
      wdata = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      addr  = '0;
      we    = 1'b0;
      wdata = '0;

      // ---- reset ----
      #100;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      rd_chk("rst_ctrl",   CTRL_OFS,   32'h0);
      rd_chk("rst_preset", PRESET_OFS, 32'h0);
      rd_chk("rst_count",  COUNT_OFS,  32'h0);
      rd_chk("rst_rsvd",   2'd3,       32'h0);
      chk("rst_irq",   {31'b0, irq}, 32'h0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));

      // ---- one-shot, PRESET = 3: irq on the 7th edge after enable ----
      wr(PRESET_OFS, 32'd3);
      wr(CTRL_OFS, 32'h9);
      addr = COUNT_OFS;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("os_irq_e%0d", k), {31'b0, irq}, (k == 7) ? 32'd1 : 32'd0);
         if (k >= 2 && k <= 5)
            chk($sformatf("os_count_e%0d", k), rdata, 32'(5 - k));
      end
      repeat (3) @(posedge clk);
      #1;
      chk("os_irq_held", {31'b0, irq}, 32'd1);
      chk("os_state", 32'(dut.state_q), 32'(IDLE));
      rd_chk("os_ctrl_en_clr", CTRL_OFS, 32'h8);

      // ---- auto-reload, PRESET = 2: pulse every 5 cycles ----
      wr(PRESET_OFS, 32'd2);
      wr(CTRL_OFS, 32'hB);
      chk("ar_irq_clr", {31'b0, irq}, 32'd0);
      addr = COUNT_OFS;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ar_irq_e%0d", k), {31'b0, irq},
             (k == 6 || k == 11 || k == 16) ? 32'd1 : 32'd0);
         if (k % 5 == 2)
            chk($sformatf("ar_reload_e%0d", k), rdata, 32'd2);
      end
      wr(CTRL_OFS, 32'h0);
      chk("ar_stop_state", 32'(dut.state_q), 32'(IDLE));
      chk("ar_stop_irq", {31'b0, irq}, 32'd0);

      // ---- disable mid-count: PRESET = 10, write CTRL = 0 at COUNT = 5 ----
      wr(PRESET_OFS, 32'd10);
      wr(CTRL_OFS, 32'h9);
      addr = COUNT_OFS;
      repeat (7) @(posedge clk);
      #1;
      chk("dis_count5", rdata, 32'd5);
      wr(CTRL_OFS, 32'h0);
      chk("dis_state", 32'(dut.state_q), 32'(IDLE));
      addr = COUNT_OFS;
      repeat (5) @(posedge clk);
      #1;
      chk("dis_count_frozen", rdata, 32'd5);
      chk("dis_irq", {31'b0, irq}, 32'd0);

      // ---- IM = 0, PRESET = 0: flag on 4th edge, irq masked ----
      wr(PRESET_OFS, 32'd0);
      wr(CTRL_OFS, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      chk("im0_flag_e3", {31'b0, dut.irq_flag_q}, 32'd0);
      @(posedge clk);
      #1;
      chk("im0_flag_e4", {31'b0, dut.irq_flag_q}, 32'd1);
      chk("im0_irq", {31'b0, irq}, 32'd0);
      rd_chk("im0_ctrl", CTRL_OFS, 32'h0);
      wr(CTRL_OFS, 32'h8);
      chk("im0_flag_clr", {31'b0, dut.irq_flag_q}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("im0_irq_after", {31'b0, irq}, 32'd0);

      // ---- ignored writes ----
      wr(COUNT_OFS, 32'h55);
      rd_chk("count_wr_ignored", COUNT_OFS, 32'd0);
      wr(2'd3, 32'hFFFF_FFFF);
      rd_chk("rsvd_reads0", 2'd3, 32'h0);
      rd_chk("ctrl_after_rsvd", CTRL_OFS, 32'h8);
      wr(CTRL_OFS, 32'hFFFF_FF00);
      rd_chk("ctrl_upper_ignored", CTRL_OFS, 32'h0);

      // ---- CTRL write coinciding with INT: bus wins ----
      wr(PRESET_OFS, 32'd0);
      wr(CTRL_OFS, 32'h9);
      repeat (3) @(posedge clk);
      #1;
      chk("sim_in_int", 32'(dut.state_q), 32'(INT));
      wr(CTRL_OFS, 32'h9);
      rd_chk("sim_ctrl", CTRL_OFS, 32'h9);
      chk("sim_irq", {31'b0, irq}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("sim_irq_e7", {31'b0, irq}, 32'd0);
      @(posedge clk);
      #1;
      chk("sim_irq_e8", {31'b0, irq}, 32'd1);

      // ---- reset mid-count ----
      wr(PRESET_OFS, 32'd10);
      wr(CTRL_OFS, 32'h9);
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      rd_chk("mrst_ctrl",   CTRL_OFS,   32'h0);
      rd_chk("mrst_preset", PRESET_OFS, 32'h0);
      rd_chk("mrst_count",  COUNT_OFS,  32'h0);
      chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
      chk("mrst_irq", {31'b0, irq}, 32'd0);

`ifdef TIMER_PRESCALE_EN
      // ---- prescaler PS = 2, PRESET = 1: irq 11 edges after enable ----
      wr(PRESET_OFS, 32'd1);
      wr(CTRL_OFS, 32'h29);
      addr = COUNT_OFS;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ps_irq_e%0d", k), {31'b0, irq}, (k == 11) ? 32'd1 : 32'd0);
         if (k == 2 || k == 5)
            chk($sformatf("ps_count_e%0d", k), rdata, 32'd1);
         if (k == 6 || k == 9)
            chk($sformatf("ps_count_e%0d", k), rdata, 32'd0);
      end
      rd_chk("ps_ctrl", CTRL_OFS, 32'h28);
`else
      // ---- CTRL.PS reads zero and ignores writes without the prescaler ----
      wr(CTRL_OFS, 32'h70);
      rd_chk("ps_absent", CTRL_OFS, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
